// File: rtl/conv1_layer1_dense_ctrl.sv
// Tile sequencer for the conv1 layer-1 dense datapath: fetch, wait for both operands, compute, repeat.
// Optional WAIT watchdog enabled by defining CONV1_CTRL_TIMEOUT_EN.
module conv1_layer1_dense_ctrl #(
    parameter int unsigned NUM_TILES   = 16,
    parameter int unsigned COMPUTE_LAT = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       fea_need_data,
    input  logic       fea_data_v,
    output logic       amx_need_data,
    input  logic       amx_data_v,
    output logic       pe_en,
    output logic [7:0] tile_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned TILE_W = 8;
    localparam int unsigned LAT_W  = 6;

    if (NUM_TILES < 1 || NUM_TILES > 256 || COMPUTE_LAT < 1 || COMPUTE_LAT > 64 ||
        TIMEOUT_CYC < 1) begin : g_bad_param
        $error("conv1_layer1_dense_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_COMPUTE,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [TILE_W-1:0]   tile_cnt_q, tile_cnt_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic                fea_got_q, fea_got_d;
    logic                amx_got_q, amx_got_d;
    logic                need_q, pe_en_q, busy_q, done_q;

`ifdef CONV1_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                err_q, err_d;
`endif

    // Next-state and counter update
    always_comb begin
        state_d    = state_q;
        tile_cnt_d = tile_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        fea_got_d  = fea_got_q;
        amx_got_d  = amx_got_q;
`ifdef CONV1_CTRL_TIMEOUT_EN
        wd_cnt_d   = '0;
        err_d      = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    tile_cnt_d = '0;
`ifdef CONV1_CTRL_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                fea_got_d = fea_got_q | fea_data_v;
                amx_got_d = amx_got_q | amx_data_v;
                if (fea_got_d && amx_got_d) begin
                    state_d   = S_COMPUTE;
                    fea_got_d = 1'b0;
                    amx_got_d = 1'b0;
                end
`ifdef CONV1_CTRL_TIMEOUT_EN
                else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_IDLE;
                    err_d     = 1'b1;
                    fea_got_d = 1'b0;
                    amx_got_d = 1'b0;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
`endif
            end
            S_COMPUTE: begin
                if (lat_cnt_q == LAT_W'(COMPUTE_LAT - 1)) begin
                    lat_cnt_d = '0;
                    if (tile_cnt_q == TILE_W'(NUM_TILES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        tile_cnt_d = tile_cnt_q + TILE_W'(1);
                        state_d    = S_FETCH;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tile_cnt_q <= '0;
            lat_cnt_q  <= '0;
            fea_got_q  <= 1'b0;
            amx_got_q  <= 1'b0;
            need_q     <= 1'b0;
            pe_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CONV1_CTRL_TIMEOUT_EN
            wd_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tile_cnt_q <= tile_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            fea_got_q  <= fea_got_d;
            amx_got_q  <= amx_got_d;
            need_q     <= (state_d == S_FETCH);
            pe_en_q    <= (state_d == S_COMPUTE);
            busy_q     <= (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_COMPUTE);
            done_q     <= (state_d == S_DONE);
`ifdef CONV1_CTRL_TIMEOUT_EN
            wd_cnt_q   <= wd_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign fea_need_data = need_q;
    assign amx_need_data = need_q;
    assign pe_en         = pe_en_q;
    assign tile_idx      = tile_cnt_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef CONV1_CTRL_TIMEOUT_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_conv1_layer1_dense_ctrl.sv
// Directed bench for conv1_layer1_dense_ctrl (NUM_TILES=4, COMPUTE_LAT=3 plus a 1x1 instance).
module tb_conv1_layer1_dense_ctrl;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, fea_v, amx_v;
    logic       fea_need_data, amx_need_data, pe_en, busy, done, err;
    logic [7:0] tile_idx;

    logic       start1, fea1, amx1;
    logic       need_f1, need_a1, pe1, busy1, done1, err1;
    logic [7:0] tile1;

    int n_chk  = 0;
    int n_pass = 0;
    int need_seen = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    conv1_layer1_dense_ctrl #(.NUM_TILES(4), .COMPUTE_LAT(3), .TIMEOUT_CYC(8)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .fea_need_data(fea_need_data), .fea_data_v(fea_v),
        .amx_need_data(amx_need_data), .amx_data_v(amx_v),
        .pe_en(pe_en), .tile_idx(tile_idx), .busy(busy), .done(done), .err(err)
    );

    conv1_layer1_dense_ctrl #(.NUM_TILES(1), .COMPUTE_LAT(1), .TIMEOUT_CYC(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .fea_need_data(need_f1), .fea_data_v(fea1),
        .amx_need_data(need_a1), .amx_data_v(amx1),
        .pe_en(pe1), .tile_idx(tile1), .busy(busy1), .done(done1), .err(err1)
    );

    always @(negedge clk) begin
        if (fea_need_data && amx_need_data) need_seen++;
        if (done) done_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered on the FETCH cycle; valids arrive on the second WAIT cycle; returns on the cycle after compute
    task automatic run_tile(input int t);
        chk("fetch_need", {30'd0, fea_need_data, amx_need_data}, 32'd3);
        chk("fetch_tile", tile_idx, t);
        chk("fetch_busy", busy, 1);
        step();
        chk("wait_pe", pe_en, 0);
        chk("wait_need", fea_need_data, 0);
        step();
        fea_v = 1'b1; amx_v = 1'b1;
        chk("wait2_pe", pe_en, 0);
        step();
        fea_v = 1'b0; amx_v = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            chk("compute_pe", pe_en, 1);
            chk("compute_tile", tile_idx, t);
            step();
        end
    endtask

    task automatic check_done();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_pe", pe_en, 0);
        step();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_tile_hold", tile_idx, 3);
    endtask

    initial begin
        int need0, done0;
        rst = 1'b0; start = 1'b0; fea_v = 1'b0; amx_v = 1'b0;
        start1 = 1'b0; fea1 = 1'b0; amx1 = 1'b0;
        step(); step();
        chk("rst_need", fea_need_data, 0);
        chk("rst_pe", pe_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tile", tile_idx, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        step();

        // Nominal run: both valids together in every WAIT
        need0 = need_seen; done0 = done_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 4; t++) run_tile(t);
        check_done();
        chk("nom_need_cnt", need_seen - need0, 4);
        chk("nom_done_cnt", done_seen - done0, 1);
        chk("nom_err", err, 0);

        // Staggered valids and a stray fea_data_v during COMPUTE
        start = 1'b1;
        step();                              // c1 FETCH
        start = 1'b0;
        chk("stg_need", fea_need_data, 1);
        step(); fea_v = 1'b1;                // c2
        step(); fea_v = 1'b0;                // c3
        step();                              // c4
        step(); amx_v = 1'b1;                // c5
        chk("stg_pe_c5", pe_en, 0);
        step(); amx_v = 1'b0;                // c6
        chk("stg_pe_c6", pe_en, 1);
        step(); fea_v = 1'b1;                // c7 stray
        chk("stg_pe_c7", pe_en, 1);
        step(); fea_v = 1'b0;                // c8
        chk("stg_pe_c8", pe_en, 1);
        step();                              // c9 FETCH tile 1
        chk("stg_fetch1", fea_need_data, 1);
        chk("stg_tile1", tile_idx, 1);
        step(); amx_v = 1'b1;                // c10
        step(); amx_v = 1'b0;                // c11
        chk("stray_ignored", pe_en, 0);
        fea_v = 1'b1;
        step(); fea_v = 1'b0;                // c12
        chk("stg_pe_c12", pe_en, 1);
        step(); step(); step();              // c15 FETCH tile 2
        run_tile(2);
        run_tile(3);
        check_done();

        // start held high across the whole run, including the DONE cycle
        need0 = need_seen; done0 = done_seen;
        start = 1'b1;
        step();
        for (int t = 0; t < 4; t++) run_tile(t);
        chk("hold_done", done, 1);
        step();
        start = 1'b0;
        chk("hold_idle_busy", busy, 0);
        step();
        chk("hold_no_rerun_busy", busy, 0);
        chk("hold_no_rerun_need", fea_need_data, 0);
        chk("hold_need_cnt", need_seen - need0, 4);
        chk("hold_done_cnt", done_seen - done0, 1);

        // Reset during COMPUTE of tile 2 aborts without done
        done0 = done_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        run_tile(0);
        run_tile(1);
        step(); step();
        fea_v = 1'b1; amx_v = 1'b1;
        step();
        fea_v = 1'b0; amx_v = 1'b0;
        chk("abort_pe_before", pe_en, 1);
        rst = 1'b0;
        step();
        chk("abort_pe", pe_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_need", fea_need_data, 0);
        chk("abort_done", done, 0);
        chk("abort_tile", tile_idx, 0);
        rst = 1'b1;
        step();
        step();
        chk("abort_stays_idle", busy, 0);
        chk("abort_no_done", done_seen - done0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 4; t++) run_tile(t);
        check_done();

`ifdef CONV1_CTRL_TIMEOUT_EN
        // Watchdog: amx never arrives, 8 WAIT cycles then abort with err
        done0 = done_seen;
        start = 1'b1;
        step();                              // c1 FETCH
        start = 1'b0;
        step(); fea_v = 1'b1;                // c2 first WAIT
        step(); fea_v = 1'b0;
        for (int c = 4; c <= 9; c++) step(); // c9 last WAIT
        chk("wd_busy_wait", busy, 1);
        chk("wd_err_wait", err, 0);
        step();                              // c10
        chk("wd_err", err, 1);
        chk("wd_busy", busy, 0);
        step();
        chk("wd_err_sticky", err, 1);
        chk("wd_no_done", done_seen - done0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("wd_err_clear", err, 0);
        for (int t = 0; t < 4; t++) run_tile(t);
        check_done();
`else
        chk("err_tied_low", err, 0);
`endif

        // Single tile, single compute cycle
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("one_need", {31'd0, need_f1 & need_a1}, 1);
        chk("one_busy", busy1, 1);
        step();
        fea1 = 1'b1; amx1 = 1'b1;
        chk("one_wait_pe", pe1, 0);
        step();
        fea1 = 1'b0; amx1 = 1'b0;
        chk("one_pe", pe1, 1);
        chk("one_tile", tile1, 0);
        step();
        chk("one_pe_off", pe1, 0);
        chk("one_done", done1, 1);
        chk("one_need_off", need_f1, 0);
        step();
        chk("one_done_off", done1, 0);
        chk("one_idle", busy1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
